inv_sqrt_seq: RTL and testbench
===============================

Name: inv_sqrt_seq

Overview:
- Top-level sequencer for the fast inverse-square-root datapath. Computes y ≈ 1/sqrt(x) for IEEE-754 single precision x.
- Forms the magic-constant seed, then runs ITERATIONS Newton-Raphson steps, y = y*(1.5 - xhalf*y*y).
- Issues each step by start/ready handshakes to one shared float multiplier and one float_sub_1d5 unit. Neither unit is instantiated here; both sit beside this block in the inv-sqrt top.

Parameters:
- ITERATIONS, 2, Newton steps after the seed (1..4).
- MAGIC, 32'h5F3759DF, seed constant.
- TIMEOUT, 64, maximum wait cycles per unit operation before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- float_in  in  32  operand x.
- float_out  out  32  result y.
- ready  out  1  result valid; level, held until next accepted start.
- busy  out  1  high from the cycle after start is accepted until ready rises.
- error  out  1  timeout abort flag; valid with ready.
- mul_start  out  1  one-cycle multiplier start.
- mul_a  out  32  multiplier operand a.
- mul_b  out  32  multiplier operand b.
- mul_result  in  32  multiplier result.
- mul_ready  in  1  multiplier done level.
- sub_start  out  1  one-cycle float_sub_1d5 start.
- sub_in  out  32  float_sub_1d5 operand.
- sub_result  in  32  1.5 - sub_in.
- sub_ready  in  1  float_sub_1d5 done level.

Behaviour:
- Clock and reset: everything runs on clk, and rst is synchronous active-high.
- Reset values: float_out=0, ready=0, busy=0, error=0, mul_start=0, sub_start=0, mul_a=mul_b=sub_in=0. State goes to IDLE and the iteration counter to 0.
- Reset mid-operation: abort immediately with no result. Any unit ready returned later is ignored while in IDLE.
- Unit handshake rules:
  - The controller holds operands stable from issue until the unit's ready is seen.
  - The unit's ready drops the cycle after start is sampled.
  - The WAIT state begins one cycle after issue and exits on the first cycle the ready input is sampled high.
- States:
  - IDLE/DONE: on start, latch float_in into x and go to CHECK. ready clears and busy sets on the next cycle.
  - CHECK (1 cycle), special cases:
    - x == +0 or -0: float_out=32'h7F800000, go to FIN.
    - sign=1, or exp==8'hFF with mantissa!=0: float_out=32'h7FC00000, go to FIN.
    - x == +inf: float_out=0, go to FIN.
    - otherwise go to SEED.
  - SEED (1 cycle):
    - y = MAGIC - (x>>1), unsigned 32-bit.
    - xhalf = {0, exp-1, mant} when exp>1; else x>>1 (denormal halving).
    - iteration counter = 0.
  - Per iteration, each operation is an ISSUE state followed by a WAIT state:
    - M1: mul a=y, b=y → t.
    - M2: mul a=xhalf, b=t → t.
    - S: sub_in=t → t.
    - M3: mul a=y, b=t → y.
  - After M3 WAIT: increment the counter. If counter==ITERATIONS, float_out=y and go to FIN; else go to M1.
  - FIN: ready=1, busy=0 in the same cycle; then DONE.
- Timeout:
  - Each WAIT counts cycles. If the count reaches TIMEOUT, set error=1 and float_out=32'h7FC00000, then go to FIN.
  - error clears on the next accepted start.
- Simultaneous events:
  - start while busy is ignored.
  - start in the same cycle as FIN is ignored; it is sampled from DONE onward.
  - rst has priority over everything.
- The first start after reset is accepted from IDLE, the same as from DONE.

Test Plan:
- Stub units with 3-cycle latency. x=32'h40800000 (4.0), ITERATIONS=2:
  - mul_a=y=32'h3EF759DF at the first M1.
  - Exactly 6 mul_start and 2 sub_start pulses.
  - float_out within 1e-5 relative of 0.5; ready high, error=0.
- x=32'h3F800000 (1.0), ITERATIONS=1:
  - seed 32'h3F7759DF.
  - float_out within 2e-3 relative of 1.0 (≈0.9983).
  - 3 mul_start and 1 sub_start pulses.
- Special cases:
  - x=0 → 32'h7F800000, ready 3 cycles after start, no mul_start/sub_start.
  - x=32'hC0000000 → 32'h7FC00000.
  - x=32'h7F800000 → 0.
- Assert rst during the first S WAIT:
  - next cycle all outputs are at reset values.
  - the late sub_ready is ignored.
  - a new start with x=4.0 completes correctly.
- Stub multiplier never raises mul_ready, TIMEOUT=16:
  - error=1 and float_out=32'h7FC00000 after 16 wait cycles.
  - the next start clears error.
- Back-to-back, bench restarts on rising ready:
  - 10 vectors complete in order.
  - start while busy changes nothing.

Source files
------------

// File: rtl/inv_sqrt_seq.sv
// Sequencer for the fast inverse square root: magic-constant seed followed by
// Newton-Raphson steps issued to an external float multiplier and 1.5-x unit.
module inv_sqrt_seq #(
    parameter int unsigned ITERATIONS = 2,
    parameter logic [31:0] MAGIC      = 32'h5F3759DF,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] float_in,
    output logic [31:0] float_out,
    output logic        ready,
    output logic        busy,
    output logic        error,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    input  logic        mul_ready,
    output logic        sub_start,
    output logic [31:0] sub_in,
    input  logic [31:0] sub_result,
    input  logic        sub_ready
);

    localparam logic [31:0] QNAN      = 32'h7FC00000;
    localparam logic [31:0] PINF      = 32'h7F800000;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [2:0]  ITER_LAST = 3'(ITERATIONS);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CHECK    = 4'd1,
        ST_SEED     = 4'd2,
        ST_M1_ISSUE = 4'd3,
        ST_M1_WAIT  = 4'd4,
        ST_M2_ISSUE = 4'd5,
        ST_M2_WAIT  = 4'd6,
        ST_S_ISSUE  = 4'd7,
        ST_S_WAIT   = 4'd8,
        ST_M3_ISSUE = 4'd9,
        ST_M3_WAIT  = 4'd10,
        ST_FIN      = 4'd11,
        ST_DONE     = 4'd12
    } state_t;

    state_t      state_r;
    logic [31:0] x_r;
    logic [31:0] y_r;
    logic [31:0] xhalf_r;
    logic [2:0]  iter_r;
    logic [15:0] wait_r;
    logic [31:0] seed_s;
    logic        in_wait_s;
    logic        unit_ready_s;

    function automatic logic is_zero(input logic [31:0] f);
        return f[30:0] == 31'd0;
    endfunction

    // Negative operands and NaNs both have no real inverse square root.
    function automatic logic is_invalid(input logic [31:0] f);
        return f[31] || ((f[30:23] == 8'hFF) && (f[22:0] != 23'd0));
    endfunction

    // Exact halving: decrement the exponent, or shift when that would leave the normal range.
    function automatic logic [31:0] halve(input logic [31:0] f);
        if (f[30:23] > 8'd1) begin
            return {1'b0, f[30:23] - 8'd1, f[22:0]};
        end else begin
            return f >> 1;
        end
    endfunction

    assign seed_s = MAGIC - (x_r >> 1);

    // Select which unit's ready line the current wait state is listening to.
    always_comb begin
        in_wait_s    = 1'b0;
        unit_ready_s = 1'b0;
        case (state_r)
            ST_M1_WAIT, ST_M2_WAIT, ST_M3_WAIT: begin
                in_wait_s    = 1'b1;
                unit_ready_s = mul_ready;
            end
            ST_S_WAIT: begin
                in_wait_s    = 1'b1;
                unit_ready_s = sub_ready;
            end
            default: begin
                in_wait_s    = 1'b0;
                unit_ready_s = 1'b0;
            end
        endcase
    end

    // Controller FSM; start pulses are raised on the transition into each issue state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            x_r       <= 32'd0;
            y_r       <= 32'd0;
            xhalf_r   <= 32'd0;
            iter_r    <= 3'd0;
            wait_r    <= 16'd0;
            float_out <= 32'd0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= 32'd0;
            mul_b     <= 32'd0;
            sub_start <= 1'b0;
            sub_in    <= 32'd0;
        end else begin
            mul_start <= 1'b0;
            sub_start <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        x_r     <= float_in;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        error   <= 1'b0;
                        state_r <= ST_CHECK;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_CHECK: begin
                    if (is_zero(x_r)) begin
                        float_out <= PINF;
                        state_r   <= ST_FIN;
                    end else if (is_invalid(x_r)) begin
                        float_out <= QNAN;
                        state_r   <= ST_FIN;
                    end else if (x_r == PINF) begin
                        float_out <= 32'd0;
                        state_r   <= ST_FIN;
                    end else begin
                        state_r <= ST_SEED;
                    end
                end
                ST_SEED: begin
                    y_r       <= seed_s;
                    xhalf_r   <= halve(x_r);
                    iter_r    <= 3'd0;
                    mul_a     <= seed_s;
                    mul_b     <= seed_s;
                    mul_start <= 1'b1;
                    state_r   <= ST_M1_ISSUE;
                end
                ST_M1_ISSUE: begin wait_r <= 16'd0; state_r <= ST_M1_WAIT; end
                ST_M2_ISSUE: begin wait_r <= 16'd0; state_r <= ST_M2_WAIT; end
                ST_S_ISSUE:  begin wait_r <= 16'd0; state_r <= ST_S_WAIT;  end
                ST_M3_ISSUE: begin wait_r <= 16'd0; state_r <= ST_M3_WAIT; end
                ST_M1_WAIT: begin
                    if (mul_ready) begin
                        mul_a     <= xhalf_r;
                        mul_b     <= mul_result;
                        mul_start <= 1'b1;
                        state_r   <= ST_M2_ISSUE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_M2_WAIT: begin
                    if (mul_ready) begin
                        sub_in    <= mul_result;
                        sub_start <= 1'b1;
                        state_r   <= ST_S_ISSUE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_S_WAIT: begin
                    if (sub_ready) begin
                        mul_a     <= y_r;
                        mul_b     <= sub_result;
                        mul_start <= 1'b1;
                        state_r   <= ST_M3_ISSUE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_M3_WAIT: begin
                    if (mul_ready) begin
                        y_r    <= mul_result;
                        iter_r <= iter_r + 3'd1;
                        if ((iter_r + 3'd1) == ITER_LAST) begin
                            float_out <= mul_result;
                            state_r   <= ST_FIN;
                        end else begin
                            mul_a     <= mul_result;
                            mul_b     <= mul_result;
                            mul_start <= 1'b1;
                            state_r   <= ST_M1_ISSUE;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_FIN: begin
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            // A stalled unit aborts the whole computation; this overrides the wait state's hold.
            if (in_wait_s && !unit_ready_s) begin
                if (wait_r == WAIT_LAST) begin
                    error     <= 1'b1;
                    float_out <= QNAN;
                    state_r   <= ST_FIN;
                end else begin
                    wait_r <= wait_r + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_sqrt_seq.sv
// Self-checking bench for inv_sqrt_seq: stub float units, a real-arithmetic
// reference of the Newton iteration, and directed vectors.
module tb_inv_sqrt_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;

    logic        start_s      [2] = '{1'b0, 1'b0};
    logic [31:0] float_in_s   [2] = '{32'd0, 32'd0};
    logic [31:0] float_out_s  [2];
    logic        ready_s      [2];
    logic        busy_s       [2];
    logic        error_s      [2];
    logic        mul_start_s  [2];
    logic [31:0] mul_a_s      [2];
    logic [31:0] mul_b_s      [2];
    logic [31:0] mul_result_s [2] = '{32'd0, 32'd0};
    logic        mul_ready_s  [2] = '{1'b0, 1'b0};
    logic        sub_start_s  [2];
    logic [31:0] sub_in_s     [2];
    logic [31:0] sub_result_s [2] = '{32'd0, 32'd0};
    logic        sub_ready_s  [2] = '{1'b0, 1'b0};

    int          mul_lat [2] = '{0, 0};
    int          sub_lat [2] = '{0, 0};
    int          mul_tot [2] = '{0, 0};
    int          sub_tot [2] = '{0, 0};
    logic [31:0] mul_hist [2][512];

    logic [31:0] exp_out   [2] = '{32'd0, 32'd0};
    logic        exp_err   [2] = '{1'b0, 1'b0};
    logic        exp_valid [2] = '{1'b0, 1'b0};

    int total = 0;
    int bad   = 0;

    inv_sqrt_seq #(.ITERATIONS(2), .TIMEOUT(16)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_s[0]), .float_in(float_in_s[0]),
        .float_out(float_out_s[0]), .ready(ready_s[0]), .busy(busy_s[0]), .error(error_s[0]),
        .mul_start(mul_start_s[0]), .mul_a(mul_a_s[0]), .mul_b(mul_b_s[0]),
        .mul_result(mul_result_s[0]), .mul_ready(mul_ready_s[0]),
        .sub_start(sub_start_s[0]), .sub_in(sub_in_s[0]),
        .sub_result(sub_result_s[0]), .sub_ready(sub_ready_s[0])
    );

    inv_sqrt_seq #(.ITERATIONS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .float_in(float_in_s[1]),
        .float_out(float_out_s[1]), .ready(ready_s[1]), .busy(busy_s[1]), .error(error_s[1]),
        .mul_start(mul_start_s[1]), .mul_a(mul_a_s[1]), .mul_b(mul_b_s[1]),
        .mul_result(mul_result_s[1]), .mul_ready(mul_ready_s[1]),
        .sub_start(sub_start_s[1]), .sub_in(sub_in_s[1]),
        .sub_result(sub_result_s[1]), .sub_ready(sub_ready_s[1])
    );

    always #5 clk = ~clk;

    // Single-precision bits to real (normal numbers and zero).
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Real to single precision, round to nearest even (normal range).
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        logic [23:0] m;
        logic [28:0] rem;
        if (r == 0.0) return 32'd0;
        d   = $realtobits(r);
        e   = d[62:52];
        m   = {1'b0, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h10000000 || (rem == 29'h10000000 && m[0])) m = m + 24'd1;
        if (m[23]) begin
            e = e + 11'd1;
            m = 24'd0;
        end
        return {d[63], 8'(e - 11'd896), m[22:0]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] fsub(input logic [31:0] a);
        return r2f(1.5 - f2r(a));
    endfunction

    function automatic logic is_special(input logic [31:0] x);
        return (x[30:0] == 31'd0) || x[31] || (x[30:23] == 8'hFF);
    endfunction

    // Reference result: special-case table, else magic seed plus Newton steps in float arithmetic.
    function automatic logic [31:0] model_y(input logic [31:0] x, input int iters);
        logic [31:0] y;
        logic [31:0] xh;
        logic [31:0] t;
        if (x[30:0] == 31'd0) return 32'h7F800000;
        if (x[31] || (x[30:23] == 8'hFF && x[22:0] != 23'd0)) return 32'h7FC00000;
        if (x == 32'h7F800000) return 32'd0;
        y  = 32'h5F3759DF - (x >> 1);
        xh = r2f(f2r(x) / 2.0);
        for (int k = 0; k < iters; k++) begin
            t = fmul(y, y);
            t = fmul(xh, t);
            t = fsub(t);
            y = fmul(y, t);
        end
        return y;
    endfunction

    function automatic logic near(input logic [31:0] f, input real want, input real tol);
        real d;
        d = f2r(f) - want;
        if (d < 0.0) d = -d;
        return d <= tol * want;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Stub units: 3-cycle latency, ready drops the cycle after start is sampled.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mul_start_s[i]) begin
                mul_ready_s[i]  <= 1'b0;
                mul_lat[i]      <= 3;
                mul_result_s[i] <= fmul(mul_a_s[i], mul_b_s[i]);
                mul_hist[i][mul_tot[i] % 512] <= mul_a_s[i];
                mul_tot[i]      <= mul_tot[i] + 1;
            end else if (mul_lat[i] != 0) begin
                mul_lat[i] <= mul_lat[i] - 1;
                if (mul_lat[i] == 1 && !(stall && i == 0)) mul_ready_s[i] <= 1'b1;
            end
            if (sub_start_s[i]) begin
                sub_ready_s[i]  <= 1'b0;
                sub_lat[i]      <= 3;
                sub_result_s[i] <= fsub(sub_in_s[i]);
                sub_tot[i]      <= sub_tot[i] + 1;
            end else if (sub_lat[i] != 0) begin
                sub_lat[i] <= sub_lat[i] - 1;
                if (sub_lat[i] == 1) sub_ready_s[i] <= 1'b1;
            end
        end
    end

    // Whenever a result is presented it must match the reference and busy must be low.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (ready_s[i] && exp_valid[i]) begin
                    chk("mon_out", float_out_s[i], exp_out[i]);
                    chk("mon_err", {31'd0, error_s[i]}, {31'd0, exp_err[i]});
                    chk("mon_busy", {31'd0, busy_s[i]}, 32'd0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input int idx);
        chk("rst_float_out", float_out_s[idx], 32'd0);
        chk("rst_ready", {31'd0, ready_s[idx]}, 32'd0);
        chk("rst_busy", {31'd0, busy_s[idx]}, 32'd0);
        chk("rst_error", {31'd0, error_s[idx]}, 32'd0);
        chk("rst_mul_start", {31'd0, mul_start_s[idx]}, 32'd0);
        chk("rst_sub_start", {31'd0, sub_start_s[idx]}, 32'd0);
        chk("rst_mul_a", mul_a_s[idx], 32'd0);
        chk("rst_mul_b", mul_b_s[idx], 32'd0);
        chk("rst_sub_in", sub_in_s[idx], 32'd0);
    endtask

    // Issue one start (called away from posedge), then follow it to the rising ready.
    task automatic run(input int idx, input logic [31:0] x, input logic stall_en, input logic poke,
                       output logic [31:0] res, output logic err, output int lat,
                       output int nmul, output int nsub, output logic [31:0] first_a);
        int  m0;
        int  s0;
        logic fin;
        stall = stall_en;
        m0 = mul_tot[idx];
        s0 = sub_tot[idx];
        float_in_s[idx] = x;
        start_s[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_s[idx] = 1'b0;
        exp_valid[idx] = 1'b1;
        exp_out[idx] = stall_en ? 32'h7FC00000 : model_y(x, (idx == 0) ? 2 : 1);
        exp_err[idx] = stall_en;
        chk("accept_busy", {31'd0, busy_s[idx]}, 32'd1);
        chk("accept_ready_low", {31'd0, ready_s[idx]}, 32'd0);
        chk("accept_err_clear", {31'd0, error_s[idx]}, 32'd0);
        lat = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 5) begin
                float_in_s[idx] = 32'h3E800000;
                start_s[idx] = 1'b1;
            end else if (poke && lat == 6) begin
                start_s[idx] = 1'b0;
            end
            if (ready_s[idx]) begin
                fin = 1'b1;
            end else if (lat >= 400) begin
                chk("ready_timeout", {31'd0, ready_s[idx]}, 32'd1);
                fin = 1'b1;
            end else if (!busy_s[idx]) begin
                chk("busy_while_running", {31'd0, busy_s[idx]}, 32'd1);
            end
        end
        start_s[idx] = 1'b0;
        res = float_out_s[idx];
        err = error_s[idx];
        nmul = mul_tot[idx] - m0;
        nsub = sub_tot[idx] - s0;
        first_a = mul_hist[idx][m0 % 512];
    endtask

    logic [31:0] res;
    logic        err;
    int          lat;
    int          nmul;
    int          nsub;
    logic [31:0] fa;
    logic [31:0] vec [10] = '{32'h40800000, 32'h40000000, 32'h41100000, 32'h3E800000, 32'h42C80000,
                              32'h3A83126F, 32'h00000000, 32'hBF800000, 32'h7FC00000, 32'h41800000};

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);

        // x = 4.0, two iterations
        run(0, 32'h40800000, 1'b0, 1'b0, res, err, lat, nmul, nsub, fa);
        chk("seed_4", fa, 32'h3EF759DF);
        chk("muls_4", 32'(nmul), 32'd6);
        chk("subs_4", 32'(nsub), 32'd2);
        chk("res_4_model", res, model_y(32'h40800000, 2));
        chk("res_4_tol", {31'd0, near(res, 0.5, 1.0e-5)}, 32'd1);
        chk("err_4", {31'd0, err}, 32'd0);

        // x = 1.0, one iteration
        run(1, 32'h3F800000, 1'b0, 1'b0, res, err, lat, nmul, nsub, fa);
        chk("seed_1", fa, 32'h3F7759DF);
        chk("muls_1", 32'(nmul), 32'd3);
        chk("subs_1", 32'(nsub), 32'd1);
        chk("res_1_tol", {31'd0, near(res, 1.0, 2.0e-3)}, 32'd1);
        chk("res_1_model", res, model_y(32'h3F800000, 1));

        // special cases
        run(0, 32'h00000000, 1'b0, 1'b0, res, err, lat, nmul, nsub, fa);
        chk("zero_out", res, 32'h7F800000);
        chk("zero_lat", 32'(lat), 32'd3);
        chk("zero_units", 32'(nmul + nsub), 32'd0);
        run(0, 32'hC0000000, 1'b0, 1'b0, res, err, lat, nmul, nsub, fa);
        chk("neg_out", res, 32'h7FC00000);
        run(0, 32'h7F800000, 1'b0, 1'b0, res, err, lat, nmul, nsub, fa);
        chk("inf_out", res, 32'h00000000);

        // reset during the first 1.5-x wait
        exp_valid[0] = 1'b0;
        exp_valid[1] = 1'b0;
        float_in_s[0] = 32'h40800000;
        start_s[0] = 1'b1;
        @(posedge clk);
        #1 start_s[0] = 1'b0;
        n = 0;
        while (!sub_start_s[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("s_issue_seen", {31'd0, sub_start_s[0]}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs(0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_ready", {31'd0, ready_s[0]}, 32'd0);
            chk("post_rst_busy", {31'd0, busy_s[0]}, 32'd0);
            chk("post_rst_mul_start", {31'd0, mul_start_s[0]}, 32'd0);
        end
        run(0, 32'h40800000, 1'b0, 1'b0, res, err, lat, nmul, nsub, fa);
        chk("rst_rerun_out", res, model_y(32'h40800000, 2));
        chk("rst_rerun_muls", 32'(nmul), 32'd6);

        // multiplier never answers: abort after 16 wait cycles
        run(0, 32'h40800000, 1'b1, 1'b0, res, err, lat, nmul, nsub, fa);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_out", res, 32'h7FC00000);
        chk("to_lat", 32'(lat), 32'd21);
        chk("to_muls", 32'(nmul), 32'd1);
        run(0, 32'h40800000, 1'b0, 1'b0, res, err, lat, nmul, nsub, fa);
        chk("to_clear_err", {31'd0, err}, 32'd0);
        chk("to_clear_out", res, model_y(32'h40800000, 2));

        // back-to-back vectors, restarting on the rising ready
        for (int v = 0; v < 10; v++) begin
            run(0, vec[v], 1'b0, (v == 3), res, err, lat, nmul, nsub, fa);
            chk("b2b_out", res, model_y(vec[v], 2));
            chk("b2b_muls", 32'(nmul), is_special(vec[v]) ? 32'd0 : 32'd6);
            chk("b2b_subs", 32'(nsub), is_special(vec[v]) ? 32'd0 : 32'd2);
            if (!is_special(vec[v])) begin
                chk("b2b_tol", {31'd0, near(res, 1.0 / $sqrt(f2r(vec[v])), 1.0e-5)}, 32'd1);
            end
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1);
    end

endmodule
